otbn_mac_mul256_seq: RTL and testbench
======================================

OTBN_MAC_MUL256_SEQ -- requirements
Module: otbn_mac_mul256_seq

Interface
REQ-001 SHALL have no parameters; WLEN=256 and QWLEN=64 are fixed by otbn_pkg.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk_i  in  1  clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 start_i  in  1  request a 256x256 multiply; only sampled in IDLE.
REQ-006 abort_i  in  1  cancel the sequence in progress.
REQ-007 operand_a_i, operand_b_i  in  256 each  multiplicands; sampled with an accepted start.
REQ-008 busy_o  out  1  high in RUN.
REQ-009 done_o  out  1  one-cycle pulse on successful completion.
REQ-010 err_o  out  1  one-cycle pulse on MAC integrity abort.
REQ-011 result_o  out  512  product; held until the next accepted start.
REQ-012 mac_en_o, mac_commit_o  out  1 each  MAC enable and accumulator commit.
REQ-013 mac_operand_a_o, mac_operand_b_o  out  256 each  latched operands.
REQ-014 mac_a_qw_sel_o, mac_b_qw_sel_o, mac_pre_acc_shift_o  out  2 each  quarter-word selects and shift (0 selects 0 bits, 1 selects 64 bits).
REQ-015 mac_zero_acc_o, mac_shift_acc_o, mac_wr_hw_sel_upper_o  out  1 each  MULQACC .Z, .SO and upper-half flags.
REQ-016 mac_predec_op_en_o, mac_predec_acc_rd_en_o  out  1 each  redundant predecode for the MAC.
REQ-017 mac_result_i  in  256  MAC adder result of the current step.
REQ-018 mac_stall_i  in  1  hold the current step.
REQ-019 mac_intg_err_i  in  1  MAC accumulator integrity violation.

Function
REQ-020 FSM states SHALL be IDLE and RUN, with a 4-bit step counter.
- IDLE to RUN on start_i, latching both operands and setting step=0.
- start_i while in RUN SHALL be ignored.
REQ-021 In RUN: mac_en_o=1 and mac_commit_o=~mac_stall_i; outside RUN all mac_* control outputs SHALL be 0.
REQ-022 The step counter SHALL advance only on a cycle where mac_commit_o=1.
REQ-023 Step table, listed as (a_qw, b_qw, shift), with flags:
- 0: (0,0,0) Z
- 1: (1,0,1)
- 2: (0,1,1) SO-lower
- 3: (2,0,0); 4: (1,1,0); 5: (0,2,0)
- 6: (3,0,1); 7: (2,1,1); 8: (1,2,1)
- 9: (0,3,1) SO-upper
- 10: (3,1,0); 11: (2,2,0); 12: (1,3,0)
- 13: (3,2,1)
- 14: (2,3,1) SO-lower
- 15: (3,3,0) SO-upper
REQ-024 Flag encoding: SO sets mac_shift_acc_o=1; upper sets mac_wr_hw_sel_upper_o=1; Z sets mac_zero_acc_o=1; all other steps drive these flags 0.
REQ-025 mac_predec_op_en_o SHALL equal mac_en_o; mac_predec_acc_rd_en_o SHALL equal mac_en_o & ~mac_zero_acc_o.
REQ-026 On a committed SO step, mac_result_i[127:0] SHALL be captured into a result staging register:
- step 2 into bits [127:0]
- step 9 into bits [255:128]
- step 14 into bits [383:256]
- step 15 into bits [511:384]
REQ-027 On commit of step 15: result_o SHALL be updated from staging, done_o SHALL pulse the next cycle, and the FSM SHALL return to IDLE.
REQ-028 Latency: with no stall, start accepted at cycle 0 means steps occupy cycles 1..16 and done_o pulses at cycle 17; each stalled cycle adds one cycle.
REQ-029 mac_intg_err_i=1 while mac_en_o=1 SHALL, on the next edge, clear result_o and staging to 0, pulse err_o, and return to IDLE.
- Integrity error takes precedence over stall and over step-15 completion.
REQ-030 abort_i in RUN SHALL return to IDLE on the next edge with no done_o and no err_o, and SHALL leave result_o unchanged.
- abort_i SHALL take precedence over completion.
- mac_intg_err_i SHALL take precedence over abort_i.
REQ-031 abort_i in IDLE SHALL have no effect.
REQ-032 mac_operand_a_o and mac_operand_b_o SHALL be constant throughout a sequence.

Reset
REQ-033 rst_i SHALL force IDLE, step=0, and result_o, staging, latched operands and all outputs to 0.
REQ-034 rst_i asserted mid-sequence SHALL take effect at that edge with no done_o or err_o pulse.

Verification
REQ-035 a=1, b=1, no stall: done_o at cycle 17 and result_o=1; the captured step sequence matches REQ-023.
REQ-036 a=b=2^256-1: result_o=2^512-2^257+1.
REQ-037 a=2^255, b=3, with mac_stall_i high for 3 cycles at step 5: done_o at cycle 20 and result_o=3*2^255.
REQ-038 mac_intg_err_i pulsed at step 3: err_o pulses once, result_o=0, busy_o low, and no done_o follows.
REQ-039 abort_i at step 7 following a completed product P: busy_o low on the next cycle and result_o still P; a start_i during RUN is ignored.

Source files
------------

// File: rtl/otbn_mac_mul256_seq.sv
// -----------------------------------------------------------------------------
// otbn_mac_mul256_seq
//
// Sequences a full 256x256 -> 512-bit multiply through the OTBN 64x64 MAC by
// issuing the 16 MULQACC steps of a schoolbook product. The operands are latched
// when the sequence starts. The lower 128 bits of the MAC adder result are
// collected on each shift-out step. The assembled product is published on
// result_o when the last step commits.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i                  begin a multiply (only sampled in IDLE)
//   abort_i                  cancel a running multiply (ignored in IDLE)
//   operand_a_i/_b_i [255:0] multiplicands, sampled with an accepted start
//   busy_o                   high while the sequence runs
//   done_o / err_o           one-cycle completion / integrity-abort pulses
//   result_o [511:0]         product, held until overwritten
//   mac_*_o                  MAC control: enable, commit, quarter-word selects,
//                            pre-accumulate shift, .Z/.SO/upper flags, predecode
//   mac_operand_a/b_o        latched operands fed to the MAC
//   mac_result_i [255:0]     MAC adder result of the current step
//   mac_stall_i              hold the current step
//   mac_intg_err_i           MAC accumulator integrity violation
//   dbg_state_o, dbg_step_o  FSM state (1 = RUN) and step counter
//
// Control semantics:
//   A start is accepted on any rising edge where start_i=1 and the FSM is
//   IDLE. While RUNning, a step is committed on every edge where mac_stall_i=0.
//   Priority inside RUN is integrity error > abort > step commit. Reset
//   overrides everything.
// -----------------------------------------------------------------------------
module otbn_mac_mul256_seq (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [255:0] operand_a_i,
  input  logic [255:0] operand_b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [511:0] result_o,
  output logic         mac_en_o,
  output logic         mac_commit_o,
  output logic [255:0] mac_operand_a_o,
  output logic [255:0] mac_operand_b_o,
  output logic [1:0]   mac_a_qw_sel_o,
  output logic [1:0]   mac_b_qw_sel_o,
  output logic [1:0]   mac_pre_acc_shift_o,
  output logic         mac_zero_acc_o,
  output logic         mac_shift_acc_o,
  output logic         mac_wr_hw_sel_upper_o,
  output logic         mac_predec_op_en_o,
  output logic         mac_predec_acc_rd_en_o,
  input  logic [255:0] mac_result_i,
  input  logic         mac_stall_i,
  input  logic         mac_intg_err_i,
  output logic         dbg_state_o,
  output logic [3:0]   dbg_step_o
);

  localparam int unsigned WLEN  = 256;
  localparam int unsigned QWLEN = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [WLEN-1:0]   op_a_q, op_a_d;
  logic [WLEN-1:0]   op_b_q, op_b_d;
  logic [2*WLEN-1:0] staging_q, staging_d;
  logic [2*WLEN-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              run;
  logic              commit;
  logic [1:0]        a_qw, b_qw, shift_sel;
  logic              zero_f, so_f, upper_f;
  logic [2*QWLEN-1:0] res_lo;

  // Only the lower half of the adder result is ever shifted out.
  logic unused_mac_hi;
  assign unused_mac_hi = ^mac_result_i[WLEN-1:2*QWLEN];

  assign run    = (state_q == ST_RUN);
  assign commit = run & ~mac_stall_i;
  assign res_lo = mac_result_i[2*QWLEN-1:0];

  // Schoolbook schedule: partial products are grouped by column weight. Each
  // SO step retires the 128 finished bits at the bottom of the accumulator.
  always_comb begin
    a_qw      = 2'd0;
    b_qw      = 2'd0;
    shift_sel = 2'd0;
    zero_f    = 1'b0;
    so_f      = 1'b0;
    upper_f   = 1'b0;
    unique case (step_q)
      4'd0:  begin a_qw = 2'd0; b_qw = 2'd0; shift_sel = 2'd0; zero_f = 1'b1; end
      4'd1:  begin a_qw = 2'd1; b_qw = 2'd0; shift_sel = 2'd1; end
      4'd2:  begin a_qw = 2'd0; b_qw = 2'd1; shift_sel = 2'd1; so_f = 1'b1; end
      4'd3:  begin a_qw = 2'd2; b_qw = 2'd0; shift_sel = 2'd0; end
      4'd4:  begin a_qw = 2'd1; b_qw = 2'd1; shift_sel = 2'd0; end
      4'd5:  begin a_qw = 2'd0; b_qw = 2'd2; shift_sel = 2'd0; end
      4'd6:  begin a_qw = 2'd3; b_qw = 2'd0; shift_sel = 2'd1; end
      4'd7:  begin a_qw = 2'd2; b_qw = 2'd1; shift_sel = 2'd1; end
      4'd8:  begin a_qw = 2'd1; b_qw = 2'd2; shift_sel = 2'd1; end
      4'd9:  begin a_qw = 2'd0; b_qw = 2'd3; shift_sel = 2'd1; so_f = 1'b1; upper_f = 1'b1; end
      4'd10: begin a_qw = 2'd3; b_qw = 2'd1; shift_sel = 2'd0; end
      4'd11: begin a_qw = 2'd2; b_qw = 2'd2; shift_sel = 2'd0; end
      4'd12: begin a_qw = 2'd1; b_qw = 2'd3; shift_sel = 2'd0; end
      4'd13: begin a_qw = 2'd3; b_qw = 2'd2; shift_sel = 2'd1; end
      4'd14: begin a_qw = 2'd2; b_qw = 2'd3; shift_sel = 2'd1; so_f = 1'b1; end
      4'd15: begin a_qw = 2'd3; b_qw = 2'd3; shift_sel = 2'd0; so_f = 1'b1; upper_f = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    staging_d = staging_q;
    result_d  = result_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          step_d  = 4'd0;
          op_a_d  = operand_a_i;
          op_b_d  = operand_b_i;
        end
      end
      ST_RUN: begin
        if (mac_intg_err_i) begin
          // Corrupted accumulator: discard everything gathered so far.
          state_d   = ST_IDLE;
          step_d    = 4'd0;
          staging_d = '0;
          result_d  = '0;
          err_d     = 1'b1;
        end else if (abort_i) begin
          state_d = ST_IDLE;
          step_d  = 4'd0;
        end else if (commit) begin
          unique case (step_q)
            4'd2:  staging_d[127:0]   = res_lo;
            4'd9:  staging_d[255:128] = res_lo;
            4'd14: staging_d[383:256] = res_lo;
            4'd15: staging_d[511:384] = res_lo;
            default: ;
          endcase
          if (step_q == 4'd15) begin
            // Publish directly so the top quarter need not wait a cycle.
            result_d = {res_lo, staging_q[383:0]};
            done_d   = 1'b1;
            state_d  = ST_IDLE;
            step_d   = 4'd0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      step_q    <= 4'd0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      staging_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      staging_q <= staging_d;
      result_q  <= result_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy_o   = run;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign result_o = result_q;

  assign mac_en_o              = run;
  assign mac_commit_o          = commit;
  assign mac_operand_a_o       = op_a_q;
  assign mac_operand_b_o       = op_b_q;
  assign mac_a_qw_sel_o        = run ? a_qw : 2'd0;
  assign mac_b_qw_sel_o        = run ? b_qw : 2'd0;
  assign mac_pre_acc_shift_o   = run ? shift_sel : 2'd0;
  assign mac_zero_acc_o        = run & zero_f;
  assign mac_shift_acc_o       = run & so_f;
  assign mac_wr_hw_sel_upper_o = run & upper_f;
  assign mac_predec_op_en_o    = run;
  assign mac_predec_acc_rd_en_o = run & ~zero_f;

  assign dbg_state_o = state_q;
  assign dbg_step_o  = step_q;

endmodule

// File: tb/tb_otbn_mac_mul256_seq.sv
// -----------------------------------------------------------------------------
// Bench for otbn_mac_mul256_seq. A behavioural 64x64 MAC with accumulator sits
// around the DUT. Expected products come from plain 512-bit multiplication.
// Drivers push the expected outcome into a queue when they issue a start. A
// monitor pops an entry on every done_o/err_o and also checks the MAC step
// schedule against the step table.
// -----------------------------------------------------------------------------
module tb_otbn_mac_mul256_seq;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         abort_i;
  logic [255:0] operand_a_i;
  logic [255:0] operand_b_i;
  logic         busy_o, done_o, err_o;
  logic [511:0] result_o;
  logic         mac_en_o, mac_commit_o;
  logic [255:0] mac_operand_a_o, mac_operand_b_o;
  logic [1:0]   mac_a_qw_sel_o, mac_b_qw_sel_o, mac_pre_acc_shift_o;
  logic         mac_zero_acc_o, mac_shift_acc_o, mac_wr_hw_sel_upper_o;
  logic         mac_predec_op_en_o, mac_predec_acc_rd_en_o;
  logic [255:0] mac_result_i;
  logic         mac_stall_i;
  logic         mac_intg_err_i;
  logic         dbg_state_o;
  logic [3:0]   dbg_step_o;

  otbn_mac_mul256_seq dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .start_i               (start_i),
    .abort_i               (abort_i),
    .operand_a_i           (operand_a_i),
    .operand_b_i           (operand_b_i),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .err_o                 (err_o),
    .result_o              (result_o),
    .mac_en_o              (mac_en_o),
    .mac_commit_o          (mac_commit_o),
    .mac_operand_a_o       (mac_operand_a_o),
    .mac_operand_b_o       (mac_operand_b_o),
    .mac_a_qw_sel_o        (mac_a_qw_sel_o),
    .mac_b_qw_sel_o        (mac_b_qw_sel_o),
    .mac_pre_acc_shift_o   (mac_pre_acc_shift_o),
    .mac_zero_acc_o        (mac_zero_acc_o),
    .mac_shift_acc_o       (mac_shift_acc_o),
    .mac_wr_hw_sel_upper_o (mac_wr_hw_sel_upper_o),
    .mac_predec_op_en_o    (mac_predec_op_en_o),
    .mac_predec_acc_rd_en_o(mac_predec_acc_rd_en_o),
    .mac_result_i          (mac_result_i),
    .mac_stall_i           (mac_stall_i),
    .mac_intg_err_i        (mac_intg_err_i),
    .dbg_state_o           (dbg_state_o),
    .dbg_step_o            (dbg_step_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural MAC ----------------
  logic [255:0] mac_acc = '0;
  logic [63:0]  qa, qb;
  logic [255:0] pp;

  always_comb begin
    qa = mac_operand_a_o[64*mac_a_qw_sel_o +: 64];
    qb = mac_operand_b_o[64*mac_b_qw_sel_o +: 64];
    pp = {128'd0, ({64'd0, qa} * {64'd0, qb})};
    if (mac_pre_acc_shift_o == 2'd1) pp = pp << 64;
    mac_result_i = (mac_zero_acc_o ? 256'd0 : mac_acc) + pp;
  end

  always @(posedge clk_i)
    if (mac_commit_o) mac_acc <= mac_shift_acc_o ? (mac_result_i >> 128) : mac_result_i;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [511:0] exp_q[$];
  logic         kind_q[$];   // 1 = integrity error expected, 0 = done expected
  logic [255:0] cur_a, cur_b;
  logic [511:0] last_good = '0;
  int           last_evt_cyc = -1;
  int           t0;
  int           tb_step = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec step table packed as {a_qw, b_qw, shift, Z, SO, upper}.
  logic [8:0] step_tbl [16];
  initial begin
    step_tbl[0]  = {2'd0, 2'd0, 2'd0, 3'b100};
    step_tbl[1]  = {2'd1, 2'd0, 2'd1, 3'b000};
    step_tbl[2]  = {2'd0, 2'd1, 2'd1, 3'b010};
    step_tbl[3]  = {2'd2, 2'd0, 2'd0, 3'b000};
    step_tbl[4]  = {2'd1, 2'd1, 2'd0, 3'b000};
    step_tbl[5]  = {2'd0, 2'd2, 2'd0, 3'b000};
    step_tbl[6]  = {2'd3, 2'd0, 2'd1, 3'b000};
    step_tbl[7]  = {2'd2, 2'd1, 2'd1, 3'b000};
    step_tbl[8]  = {2'd1, 2'd2, 2'd1, 3'b000};
    step_tbl[9]  = {2'd0, 2'd3, 2'd1, 3'b011};
    step_tbl[10] = {2'd3, 2'd1, 2'd0, 3'b000};
    step_tbl[11] = {2'd2, 2'd2, 2'd0, 3'b000};
    step_tbl[12] = {2'd1, 2'd3, 2'd0, 3'b000};
    step_tbl[13] = {2'd3, 2'd2, 2'd1, 3'b000};
    step_tbl[14] = {2'd2, 2'd3, 2'd1, 3'b010};
    step_tbl[15] = {2'd3, 2'd3, 2'd0, 3'b011};
  end

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o || err_o) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: done=%0d err=%0d with nothing expected (cycle %0d)",
                   done_o, err_o, cyc);
        end else begin
          logic [511:0] e;
          logic k;
          e = exp_q.pop_front();
          k = kind_q.pop_front();
          check("event_flags", {done_o, err_o}, {~k, k});
          check("event_result", result_o, e);
          check("event_busy_low", busy_o, 1'b0);
          if (!k) check("commit_count", tb_step, 16);
        end
        last_evt_cyc = cyc;
      end
      if (busy_o) begin
        check("en_commit", {mac_en_o, mac_commit_o}, {1'b1, ~mac_stall_i});
        check("predec", {mac_predec_op_en_o, mac_predec_acc_rd_en_o}, {1'b1, ~mac_zero_acc_o});
        if (mac_commit_o) begin
          if (tb_step > 15) begin
            check("extra_commit", tb_step, 15);
          end else begin
            check("step_fields",
                  {mac_a_qw_sel_o, mac_b_qw_sel_o, mac_pre_acc_shift_o,
                   mac_zero_acc_o, mac_shift_acc_o, mac_wr_hw_sel_upper_o},
                  step_tbl[tb_step]);
          end
          check("op_a_const", mac_operand_a_o, cur_a);
          check("op_b_const", mac_operand_b_o, cur_b);
          tb_step++;
        end
      end else begin
        check("idle_ctrl_zero",
              {mac_en_o, mac_commit_o, mac_a_qw_sel_o, mac_b_qw_sel_o, mac_pre_acc_shift_o,
               mac_zero_acc_o, mac_shift_acc_o, mac_wr_hw_sel_upper_o,
               mac_predec_op_en_o, mac_predec_acc_rd_en_o}, 0);
        tb_step = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 256'd1 << $urandom_range(0, 255);
      default: return rand256();
    endcase
  endfunction

  // Presents a start during the current cycle (cycle t0) and returns in t0+1.
  task automatic issue_start(input logic [255:0] a, input logic [255:0] b);
    operand_a_i = a;
    operand_b_i = b;
    cur_a       = a;
    cur_b       = b;
    start_i     = 1'b1;
    t0          = cyc;
    tick();
    start_i     = 1'b0;
    operand_a_i = rand256();
    operand_b_i = rand256();
  endtask

  task automatic run_seq(input logic [255:0] a, input logic [255:0] b, input logic [511:0] exp,
                         input int pct, input int st_at, input int st_len);
    int n;
    int stalls;
    logic s;
    n = 0;
    stalls = 0;
    exp_q.push_back(exp);
    kind_q.push_back(1'b0);
    issue_start(a, b);
    while (busy_o && n < 200) begin
      s = 1'b0;
      if (pct > 0 && $urandom_range(0, 99) < pct) s = 1'b1;
      if ((cyc - t0) >= st_at && (cyc - t0) < st_at + st_len) s = 1'b1;
      mac_stall_i = s;
      if (s) stalls++;
      tick();
      n++;
    end
    mac_stall_i = 1'b0;
    if (n >= 200) check("run_timeout", n, 0);
    tick();
    check("done_latency", last_evt_cyc, t0 + 17 + stalls);
    last_good = exp;
  endtask

  // Drives into step k's cycle (t0+k+1), assuming we are at cycle t0+1.
  task automatic goto_step(input int k);
    repeat (k) tick();
  endtask

  task automatic idle_quiet(input int n);
    repeat (n) tick();
    check("idle_busy", busy_o, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] a, b;
    logic [511:0] e;

    rst_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    operand_a_i = rand256();
    operand_b_i = rand256();
    mac_stall_i = 1'b0;
    mac_intg_err_i = 1'b0;
    cur_a = '0;
    cur_b = '0;
    repeat (3) tick();
    check("rst_flags", {busy_o, done_o, err_o, mac_en_o, mac_commit_o, dbg_state_o, dbg_step_o}, 0);
    check("rst_result", result_o, 0);
    check("rst_ops", {mac_operand_a_o, mac_operand_b_o}, 0);
    rst_i = 1'b0;
    tick();

    // a=1, b=1, no stall
    run_seq(256'd1, 256'd1, 512'd1, 0, 0, 0);
    // all-ones operands
    e = '1;
    e = e - (512'd1 << 257) + 512'd2;
    run_seq('1, '1, e, 0, 0, 0);
    // 2^255 * 3 with three stalled cycles at step 5 (cycle t0+6)
    run_seq(256'd1 << 255, 256'd3, 512'd3 << 255, 0, 6, 3);

    // randomized operands with random stalls
    for (int i = 0; i < 24; i++) begin
      a = pick_operand();
      b = pick_operand();
      run_seq(a, b, {256'd0, a} * {256'd0, b}, (i % 3) * 15, 0, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // integrity error at step 3
    exp_q.push_back('0);
    kind_q.push_back(1'b1);
    issue_start(rand256(), rand256());
    goto_step(3);
    mac_intg_err_i = 1'b1;
    tick();
    mac_intg_err_i = 1'b0;
    tick();
    check("intg_err_cycle", last_evt_cyc, t0 + 5);
    check("intg_result", result_o, 0);
    idle_quiet(25);
    last_good = '0;

    // integrity error beats completion (step 15) and stall (step 8)
    for (int i = 0; i < 2; i++) begin
      a = rand256();
      b = rand256();
      run_seq(a, b, {256'd0, a} * {256'd0, b}, 0, 0, 0);
      exp_q.push_back('0);
      kind_q.push_back(1'b1);
      issue_start(rand256(), rand256());
      goto_step(i == 0 ? 15 : 8);
      mac_intg_err_i = 1'b1;
      mac_stall_i = (i == 1);
      tick();
      mac_intg_err_i = 1'b0;
      mac_stall_i = 1'b0;
      tick();
      check("intg_prec_cycle", last_evt_cyc, t0 + (i == 0 ? 17 : 10));
      idle_quiet(20);
      last_good = '0;
    end

    // completed product P, then a run with an ignored start and abort at step 7
    a = rand256();
    b = rand256();
    run_seq(a, b, {256'd0, a} * {256'd0, b}, 0, 0, 0);
    issue_start(rand256(), rand256());
    goto_step(2);
    start_i = 1'b1;
    operand_a_i = rand256();
    operand_b_i = rand256();
    tick();
    start_i = 1'b0;
    goto_step(4);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_busy", busy_o, 1'b0);
    check("abort_keeps_result", result_o, last_good);
    idle_quiet(25);

    // abort beats completion at step 15
    issue_start(rand256(), rand256());
    goto_step(15);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort15_busy", busy_o, 1'b0);
    check("abort15_result", result_o, last_good);
    idle_quiet(25);

    // integrity error beats abort
    exp_q.push_back('0);
    kind_q.push_back(1'b1);
    issue_start(rand256(), rand256());
    goto_step(10);
    abort_i = 1'b1;
    mac_intg_err_i = 1'b1;
    tick();
    abort_i = 1'b0;
    mac_intg_err_i = 1'b0;
    tick();
    check("intg_over_abort_cycle", last_evt_cyc, t0 + 12);
    idle_quiet(10);
    last_good = '0;

    // abort in IDLE (coincident with start) has no effect
    abort_i = 1'b1;
    a = rand256();
    b = rand256();
    exp_q.push_back({256'd0, a} * {256'd0, b});
    kind_q.push_back(1'b0);
    issue_start(a, b);
    abort_i = 1'b0;
    repeat (17) tick();
    check("idle_abort_done_cycle", last_evt_cyc, t0 + 17);
    last_good = {256'd0, a} * {256'd0, b};

    // reset mid-sequence
    issue_start(rand256(), rand256());
    goto_step(5);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid_flags", {busy_o, done_o, err_o}, 0);
    check("rst_mid_result", result_o, 0);
    idle_quiet(25);

    // one more product after reset
    a = rand256();
    b = rand256();
    run_seq(a, b, {256'd0, a} * {256'd0, b}, 20, 0, 0);

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
